// File: rtl/vjtag_reg_master.sv
// vjtag_reg_master
//   Initiator for the 2-bit-IR virtual-JTAG register protocol. It turns host
//   register commands into tck/tdi/ir_in/vs_cdr/vs_sdr/vs_udr sequences and
//   returns the read data it captures from tdo. It drives the responder
//   bridge directly. It serves as an on-chip self-test master and as the
//   bring-up sequencer when no PC host is attached.
//
//   Protocol: IR=01 is a single-phase WRITE_REG scan. IR=10 is a two-phase
//   READ_REG scan. The DR is {data[31:0], addr[7:0]} and is shifted LSB first.
//
// Ports
//   clk_sys, rst_sys_n          system clock, async active-low reset
//   cmd_valid/ready             command handshake
//   cmd_write/addr/wdata        command: 1=write / 0=read, address, write data
//   rsp_valid                   one-cycle pulse when a command completes
//   rsp_rdata, rsp_err          read data; flags the 32'hDEADBEEF unmapped marker
//   busy                        transaction in flight
//   tck, tdi, tdo               generated JTAG clock and serial data
//   ir_in, vs_cdr/sdr/udr       instruction and DR state flags to the responder
//
// State table
//   state  | meaning
//   IDLE   | ready for a command; after accept, wait for the next tck fall
//   IR     | ir_in presented, all vs_* low, for one tck
//   CDR    | vs_cdr high for one tck; shift register (re)loaded
//   SDR    | vs_sdr high for DRW tck, one DR bit per tck
//   UDR    | vs_udr high for one tck
//   GAP    | read only: GAP_TCK idle tck between phase 1 and phase 2
//   DONE   | ir_in back to 00; respond and return to IDLE
module vjtag_reg_master #(
  parameter int TCK_DIV = 2,
  parameter int DRW     = 40,
  parameter int GAP_TCK = 6
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        tck,
  output logic        tdi,
  input  logic        tdo,
  output logic [1:0]  ir_in,
  output logic        vs_cdr,
  output logic        vs_sdr,
  output logic        vs_udr
);

  localparam int DIV_W  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int GAP_W  = (GAP_TCK > 1) ? $clog2(GAP_TCK) : 1;
  localparam int ADDR_W = 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TCK - 1);
  localparam logic [5:0]       BIT_LAST = 6'(DRW - 1);
  localparam logic [5:0]       BIT_DATA = 6'(ADDR_W);

  localparam logic [1:0]  IR_NONE  = 2'b00;
  localparam logic [1:0]  IR_WRITE = 2'b01;
  localparam logic [1:0]  IR_READ  = 2'b10;
  localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IR   = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_GAP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [5:0]       bit_cnt;
  logic [DRW-1:0]   shreg;
  logic [31:0]      cap_data;
  logic             write_q;
  logic             phase2_q;
  logic [7:0]       addr_q;
  logic [31:0]      data_q;

  logic tick;
  logic fall_evt;
  logic rise_evt;

  // The tck register flips on tick. A fall or rise event is therefore the
  // cycle whose clock edge moves tck, and the control outputs updated in that
  // same edge change together with the falling edge of tck.
  assign tick     = (div_cnt == '0);
  assign fall_evt = tick & tck;
  assign rise_evt = tick & ~tck;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state     <= S_IDLE;
      div_cnt   <= DIV_LAST;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      cap_data  <= '0;
      write_q   <= 1'b0;
      phase2_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      tck       <= 1'b0;
      tdi       <= 1'b0;
      ir_in     <= IR_NONE;
      vs_cdr    <= 1'b0;
      vs_sdr    <= 1'b0;
      vs_udr    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      // tck runs even in IDLE so the responder's tck-domain synchronizers
      // keep advancing.
      if (tick) begin
        div_cnt <= DIV_LAST;
        tck     <= ~tck;
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end

      // The value of tdo before the responder's posedge is captured. Only the
      // data field is kept. The echoed address in bits [7:0] is ignored.
      if (rise_evt && (state == S_SDR) && (bit_cnt >= BIT_DATA)) begin
        cap_data <= {tdo, cap_data[31:1]};
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            write_q   <= cmd_write;
            addr_q    <= cmd_addr;
            data_q    <= cmd_write ? cmd_wdata : 32'h0;
            phase2_q  <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end else if (busy && fall_evt) begin
            state <= S_IR;
            ir_in <= write_q ? IR_WRITE : IR_READ;
          end
        end

        S_IR: begin
          if (fall_evt) begin
            state   <= S_CDR;
            vs_cdr  <= 1'b1;
            bit_cnt <= '0;
            shreg   <= DRW'({data_q, addr_q});
          end
        end

        S_CDR: begin
          if (fall_evt) begin
            state  <= S_SDR;
            vs_cdr <= 1'b0;
            vs_sdr <= 1'b1;
            tdi    <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end

        S_SDR: begin
          if (fall_evt) begin
            if (bit_cnt == BIT_LAST) begin
              state  <= S_UDR;
              vs_sdr <= 1'b0;
              vs_udr <= 1'b1;
              tdi    <= 1'b0;
            end else begin
              tdi     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_UDR: begin
          if (fall_evt) begin
            vs_udr <= 1'b0;
            if (!write_q && !phase2_q) begin
              // Phase 1 only latched the address. ir_in stays at READ while
              // the responder fetches and synchronizes the data.
              state    <= S_GAP;
              gap_cnt  <= '0;
              phase2_q <= 1'b1;
            end else begin
              state <= S_DONE;
              ir_in <= IR_NONE;
            end
          end
        end

        S_GAP: begin
          if (fall_evt) begin
            if (gap_cnt == GAP_LAST) begin
              // Phase 2 shifts the same address again. Its UDR re-latches
              // the same address, which does no harm.
              state   <= S_CDR;
              vs_cdr  <= 1'b1;
              bit_cnt <= '0;
              shreg   <= DRW'({data_q, addr_q});
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= write_q ? 32'h0 : cap_data;
          rsp_err   <= !write_q && (cap_data == UNMAPPED);
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          phase2_q  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          ir_in     <= IR_NONE;
          vs_cdr    <= 1'b0;
          vs_sdr    <= 1'b0;
          vs_udr    <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
